// File: rtl/seq_cla_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder that streams 16-bit chunks, LSB first, through one carry-lookahead slice.
// Optional subtract support is enabled by defining ADD_SUB_EN (adds a 'sub' input port).
module seq_cla_adder_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int N  = WIDTH / 16;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two-level carry-lookahead over four 4-bit groups; returns {carry_out, sum}.
    function automatic logic [16:0] cla16(input logic [15:0] x, input logic [15:0] y, input logic ci);
        logic [15:0] g;
        logic [15:0] p;
        logic [15:0] c;
        logic [4:0]  gc;
        logic        gg;
        logic        gp;
        g  = x & y;
        p  = x ^ y;
        c  = 16'd0;
        gc = 5'd0;
        gc[0] = ci;
        for (int j = 0; j < 4; j++) begin
            gg = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp = &p[4*j +: 4];
            gc[j+1] = gg | (gp & gc[j]);
            c[4*j]  = gc[j];
            for (int i = 1; i < 4; i++) begin
                c[4*j+i] = g[4*j+i-1] | (p[4*j+i-1] & c[4*j+i-1]);
            end
        end
        return {gc[4], p ^ c};
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] a_reg_r;
    logic [WIDTH-1:0] b_reg_r;
    logic             carry_r;
    logic [KW-1:0]    k_r;
    logic [WIDTH-1:0] sum_r;
    logic             c_out_r;
    logic             ovf_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic [15:0]      a_chunk_s;
    logic [15:0]      b_chunk_s;
    logic [15:0]      slice_sum_s;
    logic             slice_co_s;
    logic             last_chunk_s;
    logic [WIDTH-1:0] b_load_s;
    logic             carry_load_s;

    // Operand preparation at acceptance: subtraction becomes a + ~b + 1.
    always_comb begin
`ifdef ADD_SUB_EN
        b_load_s     = sub ? ~b : b;
        carry_load_s = sub ? 1'b1 : c_in;
`else
        b_load_s     = b;
        carry_load_s = c_in;
`endif
    end

    // Select the active chunk and run it through the single shared slice.
    always_comb begin
        a_chunk_s = 16'd0;
        b_chunk_s = 16'd0;
        for (int i = 0; i < N; i++) begin
            a_chunk_s = (k_r == KW'(i)) ? a_reg_r[i*16 +: 16] : a_chunk_s;
            b_chunk_s = (k_r == KW'(i)) ? b_reg_r[i*16 +: 16] : b_chunk_s;
        end
        {slice_co_s, slice_sum_s} = cla16(a_chunk_s, b_chunk_s, carry_r);
        last_chunk_s = (k_r == KW'(N - 1));
    end

    // Control FSM, operand/carry registers and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_reg_r     <= '0;
            b_reg_r     <= '0;
            carry_r     <= 1'b0;
            k_r         <= '0;
            sum_r       <= '0;
            c_out_r     <= 1'b0;
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_reg_r    <= a;
                        b_reg_r    <= b_load_s;
                        carry_r    <= carry_load_s;
                        k_r        <= '0;
                        in_ready_r <= 1'b0;
                        state_r    <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < N; i++) begin
                        if (k_r == KW'(i)) begin
                            sum_r[i*16 +: 16] <= slice_sum_s;
                        end
                    end
                    carry_r <= slice_co_s;
                    k_r     <= k_r + KW'(1);
                    if (last_chunk_s) begin
                        // b_reg already holds ~b when subtracting, so its MSB is the effective sign.
                        c_out_r     <= slice_co_s;
                        ovf_r       <= (a_reg_r[WIDTH-1] == b_reg_r[WIDTH-1]) &&
                                       (slice_sum_s[15] != a_reg_r[WIDTH-1]);
                        k_r         <= '0;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign c_out     = c_out_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_seq_cla_adder_ctrl.sv
// Scoreboard bench for seq_cla_adder_ctrl (WIDTH=64): random and directed operand pairs
// checked against an arithmetic reference model; subtract cases run when ADD_SUB_EN is defined.
module tb_seq_cla_adder_ctrl;

    localparam int W   = 64;
    localparam int LAT = 5;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         c_in_i;
    logic         sub_i;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rdy_mode = 2;

    logic [65:0] exp_q[$];

    seq_cla_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .b         (b_i),
        .c_in      (c_in_i),
`ifdef ADD_SUB_EN
        .sub       (sub_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference: plain wide arithmetic; ovf from a one-bit sign-extended result.
    function automatic logic [65:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci, input logic s);
        logic [W:0] u;
        logic [W:0] sg;
        logic       co;
        if (s) begin
            u  = {1'b0, x} - {1'b0, y};
            co = (x >= y);
            sg = {x[W-1], x} - {y[W-1], y};
        end else begin
            u  = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
            co = u[W];
            sg = {x[W-1], x} + {y[W-1], y} + (W+1)'(ci);
        end
        return {sg[W] != sg[W-1], co, u[W-1:0]};
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Consumer-side readiness: random, held low, or held high.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'($urandom_range(0, 1));
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: handshake/protocol checks, latency, and scoreboard pops.
    initial begin
        logic        busy;
        logic        ov_prev;
        int          t_acc;
        logic [65:0] e;
        busy    = 1'b0;
        ov_prev = 1'b0;
        t_acc   = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy    = 1'b0;
                ov_prev = 1'b0;
                exp_q.delete();
                chk("rst_in_ready", 64'(in_ready), 64'd1);
                chk("rst_out_valid", 64'(out_valid), 64'd0);
                chk("rst_sum", sum, 64'd0);
            end else begin
                chk("in_ready_vs_busy", 64'(in_ready), 64'(!busy));
                if (out_valid && !busy) chk("out_valid_when_idle", 64'(out_valid), 64'd0);
                if (out_valid && !ov_prev) chk("latency", 64'(cyc - t_acc), 64'(LAT));
                ov_prev = out_valid;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sum", sum, e[63:0]);
                        chk("c_out", 64'(c_out), 64'(e[64]));
                        chk("ovf", 64'(ovf), 64'(e[65]));
                    end
                    busy = 1'b0;
                end
                if (in_valid && in_ready) begin
                    busy  = 1'b1;
                    t_acc = cyc;
                end
            end
        end
    end

    // Present one operand pair until accepted; push the expected response on acceptance.
    task automatic do_txn(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s);
        int n;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a_i      = x;
        b_i      = y;
        c_in_i   = ci;
        sub_i    = s;
        n        = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 64'd1, 64'd0);
                break;
            end
        end
        if (in_ready) exp_q.push_back(model(x, y, ci, s));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_i      = {$urandom, $urandom};
        b_i      = {$urandom, $urandom};
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk(name, 64'd0, 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [65:0]  hexp;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a_i      = 64'd0;
        b_i      = 64'd0;
        c_in_i   = 1'b0;
        sub_i    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        rdy_mode = 2;
        do_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        do_txn(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        do_txn(64'h0000_1234_0000_FFFF, 64'h0000_0001_0000_0001, 1'b1, 1'b0);
        do_txn(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
        drain();

        // Result must hold while the consumer stalls; new operands are ignored.
        rdy_mode = 1;
        hexp = model(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
        do_txn(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
        wait_valid("hold_valid_timeout");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            a_i      = {$urandom, $urandom};
            b_i      = {$urandom, $urandom};
            @(negedge clk);
            chk("hold_sum", sum, hexp[63:0]);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        rdy_mode = 2;
        do_txn(64'd100, 64'd23, 1'b0, 1'b0);
        drain();

        // Asynchronous reset in the middle of a computation.
        do_txn(64'hDEAD_BEEF_0000_0001, 64'h1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_in_ready", 64'(in_ready), 64'd1);
        chk("midrun_rst_out_valid", 64'(out_valid), 64'd0);
        chk("midrun_rst_c_out", 64'(c_out), 64'd0);
        chk("midrun_rst_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_txn(64'd5, 64'd3, 1'b0, 1'b0);
        drain();

`ifdef ADD_SUB_EN
        do_txn(64'd5, 64'd7, 1'b0, 1'b1);
        do_txn(64'd7, 64'd5, 1'b1, 1'b1);
        do_txn(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
        drain();
`endif

        rdy_mode = 0;
        for (int i = 0; i < 30; i++) begin
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            if (i % 5 == 0) y = ~x;
            if (i % 7 == 0) x[63] = y[63];
`ifdef ADD_SUB_EN
            do_txn(x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
            do_txn(x, y, 1'($urandom_range(0, 1)), 1'b0);
`endif
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
